// File: rtl/vdp_shift_pipe.sv
// vdp_shift_pipe: double-buffered VDP pixel serialiser.
// A one-entry cell buffer feeds a shifter that holds each pixel for HREP clocks.
//
// state | meaning
// IDLE  | shifter empty, waiting for a buffered cell
// RUN   | shifter emitting the pixels of the current cell
module vdp_shift_pipe #(
    parameter int PAT_W    = 8,
    parameter int COL_W    = 4,
    parameter int HREP     = 3,
    parameter int TEXT_PIX = 6
) (
    input  logic               clk40m,
    input  logic               rst,
    input  logic               pat_valid,
    output logic               pat_ready,
    input  logic [PAT_W-1:0]   pattern,
    input  logic [2*COL_W-1:0] color,
    input  logic [COL_W-1:0]   fg_text,
    input  logic [COL_W-1:0]   bg_text,
    input  logic [COL_W-1:0]   backdrop,
    input  logic [1:0]         mode,
    input  logic               flush,
    output logic               pix_valid,
    output logic [COL_W-1:0]   pix_color,
    output logic               underrun
);

    localparam int PIX_CW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam int REP_CW = (HREP > 1) ? $clog2(HREP) : 1;

    localparam logic [PIX_CW-1:0] PIX_LAST_FULL = PIX_CW'(PAT_W - 1);
    localparam logic [PIX_CW-1:0] PIX_LAST_TEXT = PIX_CW'(TEXT_PIX - 1);
    localparam logic [PIX_CW-1:0] PIX_HALF      = PIX_CW'(PAT_W / 2);
    localparam logic [PIX_CW-1:0] PIX_ONE       = PIX_CW'(1);
    localparam logic [REP_CW-1:0] REP_LAST      = REP_CW'(HREP - 1);
    localparam logic [REP_CW-1:0] REP_ONE       = REP_CW'(1);

    localparam logic [1:0] MODE_GFX   = 2'd0;
    localparam logic [1:0] MODE_TEXT  = 2'd1;
    localparam logic [1:0] MODE_MULTI = 2'd2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t state, state_nxt;

    logic               buf_full;
    logic [PAT_W-1:0]   buf_pat;
    logic [2*COL_W-1:0] buf_col;
    logic [COL_W-1:0]   buf_fg;
    logic [COL_W-1:0]   buf_bg;
    logic [1:0]         buf_mode;

    logic [PAT_W-1:0]   sh_pat, sh_pat_nxt;
    logic [2*COL_W-1:0] sh_col, sh_col_nxt;
    logic [COL_W-1:0]   sh_fg, sh_fg_nxt;
    logic [COL_W-1:0]   sh_bg, sh_bg_nxt;
    logic [1:0]         sh_mode, sh_mode_nxt;

    logic [PIX_CW-1:0]  pix_cnt, pix_nxt, pix_last;
    logic [REP_CW-1:0]  rep_cnt, rep_nxt;

    logic               xfer;
    logic               accept;
    logic               underrun_nxt;
    logic               pix_valid_nxt;
    logic [COL_W-1:0]   pix_color_nxt;

    function automatic logic [COL_W-1:0] resolve(
        input logic               bit_on,
        input logic [1:0]         m,
        input logic               left_half,
        input logic [2*COL_W-1:0] col,
        input logic [COL_W-1:0]   fg,
        input logic [COL_W-1:0]   bg,
        input logic [COL_W-1:0]   bd
    );
        logic [COL_W-1:0] idx;
        case (m)
            MODE_GFX:   idx = bit_on ? col[2*COL_W-1:COL_W] : col[COL_W-1:0];
            MODE_TEXT:  idx = bit_on ? fg : bg;
            MODE_MULTI: idx = left_half ? col[2*COL_W-1:COL_W] : col[COL_W-1:0];
            default:    idx = bd;
        endcase
        // index 0 is transparent and shows the backdrop
        return (idx == '0) ? bd : idx;
    endfunction

    assign pix_last  = (sh_mode == MODE_TEXT) ? PIX_LAST_TEXT : PIX_LAST_FULL;
    assign pat_ready = !rst && !flush && (!buf_full || xfer);
    assign accept    = pat_valid && pat_ready;

    always_comb begin
        state_nxt    = state;
        rep_nxt      = rep_cnt;
        pix_nxt      = pix_cnt;
        sh_pat_nxt   = sh_pat;
        sh_col_nxt   = sh_col;
        sh_fg_nxt    = sh_fg;
        sh_bg_nxt    = sh_bg;
        sh_mode_nxt  = sh_mode;
        underrun_nxt = 1'b0;
        xfer         = 1'b0;

        if (flush) begin
            state_nxt   = IDLE;
            rep_nxt     = '0;
            pix_nxt     = '0;
            sh_pat_nxt  = '0;
            sh_col_nxt  = '0;
            sh_fg_nxt   = '0;
            sh_bg_nxt   = '0;
            sh_mode_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (buf_full) begin
                        xfer = 1'b1;
                    end
                end
                RUN: begin
                    if (rep_cnt == REP_LAST) begin
                        rep_nxt = '0;
                        if (pix_cnt == pix_last) begin
                            if (buf_full) begin
                                xfer = 1'b1;
                            end else begin
                                state_nxt    = IDLE;
                                pix_nxt      = '0;
                                underrun_nxt = 1'b1;
                                sh_pat_nxt   = '0;
                                sh_col_nxt   = '0;
                                sh_fg_nxt    = '0;
                                sh_bg_nxt    = '0;
                                sh_mode_nxt  = '0;
                            end
                        end else begin
                            pix_nxt    = pix_cnt + PIX_ONE;
                            sh_pat_nxt = {sh_pat[PAT_W-2:0], 1'b0};
                        end
                    end else begin
                        rep_nxt = rep_cnt + REP_ONE;
                    end
                end
                default: state_nxt = IDLE;
            endcase

            if (xfer) begin
                state_nxt   = RUN;
                rep_nxt     = '0;
                pix_nxt     = '0;
                sh_pat_nxt  = buf_pat;
                sh_col_nxt  = buf_col;
                sh_fg_nxt   = buf_fg;
                sh_bg_nxt   = buf_bg;
                sh_mode_nxt = buf_mode;
            end
        end

        // outputs are resolved from the post-edge shifter contents
        pix_valid_nxt = (state_nxt == RUN);
        pix_color_nxt = '0;
        if (pix_valid_nxt) begin
            pix_color_nxt = resolve(sh_pat_nxt[PAT_W-1], sh_mode_nxt,
                                    (pix_nxt < PIX_HALF), sh_col_nxt,
                                    sh_fg_nxt, sh_bg_nxt, backdrop);
        end
    end

    always_ff @(posedge clk40m) begin
        if (rst || flush) begin
            buf_full <= 1'b0;
            buf_pat  <= '0;
            buf_col  <= '0;
            buf_fg   <= '0;
            buf_bg   <= '0;
            buf_mode <= '0;
        end else if (accept) begin
            buf_full <= 1'b1;
            buf_pat  <= pattern;
            buf_col  <= color;
            buf_fg   <= fg_text;
            buf_bg   <= bg_text;
            buf_mode <= mode;
        end else if (xfer) begin
            buf_full <= 1'b0;
        end
    end

    always_ff @(posedge clk40m) begin
        if (rst) begin
            state     <= IDLE;
            rep_cnt   <= '0;
            pix_cnt   <= '0;
            sh_pat    <= '0;
            sh_col    <= '0;
            sh_fg     <= '0;
            sh_bg     <= '0;
            sh_mode   <= '0;
            pix_valid <= 1'b0;
            pix_color <= '0;
            underrun  <= 1'b0;
        end else begin
            state     <= state_nxt;
            rep_cnt   <= rep_nxt;
            pix_cnt   <= pix_nxt;
            sh_pat    <= sh_pat_nxt;
            sh_col    <= sh_col_nxt;
            sh_fg     <= sh_fg_nxt;
            sh_bg     <= sh_bg_nxt;
            sh_mode   <= sh_mode_nxt;
            pix_valid <= pix_valid_nxt;
            pix_color <= pix_color_nxt;
            underrun  <= underrun_nxt;
        end
    end

endmodule

// File: tb/tb_vdp_shift_pipe.sv
// Testbench for vdp_shift_pipe: directed scenarios plus a randomized gapless stream
// checked against a per-pixel reference model.
module tb_vdp_shift_pipe;

    localparam int PAT_W    = 8;
    localparam int COL_W    = 4;
    localparam int HREP     = 3;
    localparam int TEXT_PIX = 6;

    localparam logic [3:0] EXP_A5   [8]  = '{4'h4, 4'h1, 4'h4, 4'h1, 4'h1, 4'h4, 4'h1, 4'h4};
    localparam logic [3:0] EXP_0F   [8]  = '{4'h7, 4'h7, 4'h7, 4'h7, 4'h4, 4'h4, 4'h4, 4'h4};
    localparam logic [3:0] EXP_TEXT [12] = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF,
                                             4'hF, 4'h4, 4'h4, 4'h4, 4'h4, 4'hF};

    logic               clk40m    = 1'b0;
    logic               rst       = 1'b1;
    logic               pat_valid = 1'b0;
    logic               pat_ready;
    logic [PAT_W-1:0]   pattern   = '0;
    logic [2*COL_W-1:0] color     = '0;
    logic [COL_W-1:0]   fg_text   = '0;
    logic [COL_W-1:0]   bg_text   = '0;
    logic [COL_W-1:0]   backdrop  = '0;
    logic [1:0]         mode      = '0;
    logic               flush     = 1'b0;
    logic               pix_valid;
    logic [COL_W-1:0]   pix_color;
    logic               underrun;

    int n_cmp = 0;
    int n_bad = 0;

    vdp_shift_pipe #(
        .PAT_W(PAT_W), .COL_W(COL_W), .HREP(HREP), .TEXT_PIX(TEXT_PIX)
    ) dut (
        .clk40m(clk40m), .rst(rst), .pat_valid(pat_valid), .pat_ready(pat_ready),
        .pattern(pattern), .color(color), .fg_text(fg_text), .bg_text(bg_text),
        .backdrop(backdrop), .mode(mode), .flush(flush), .pix_valid(pix_valid),
        .pix_color(pix_color), .underrun(underrun)
    );

    always #5 clk40m = ~clk40m;

    // Colour of pixel k of a cell, straight from the display rules.
    function automatic logic [COL_W-1:0] ref_pix(
        input logic [PAT_W-1:0] p, input logic [2*COL_W-1:0] c, input logic [1:0] m,
        input logic [COL_W-1:0] fg, input logic [COL_W-1:0] bg,
        input logic [COL_W-1:0] bd, input int k);
        logic [COL_W-1:0] r;
        logic             b;
        b = p[PAT_W-1-k];
        case (m)
            2'd0:    r = b ? c[2*COL_W-1:COL_W] : c[COL_W-1:0];
            2'd1:    r = b ? fg : bg;
            2'd2:    r = (k < PAT_W/2) ? c[2*COL_W-1:COL_W] : c[COL_W-1:0];
            default: r = bd;
        endcase
        if (r == '0) r = bd;
        return r;
    endfunction

    task automatic step();
        @(posedge clk40m);
        #1;
    endtask

    // Offers one cell and returns just after the edge that accepted it.
    task automatic offer(input logic [PAT_W-1:0] p, input logic [2*COL_W-1:0] c,
                         input logic [1:0] m, input logic [COL_W-1:0] fg,
                         input logic [COL_W-1:0] bg);
        bit ok;
        ok = 1'b0;
        pattern = p; color = c; mode = m; fg_text = fg; bg_text = bg;
        pat_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            #1;
            ok = pat_ready;
            step();
        end
        pat_valid = 1'b0;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL offer_timeout: pat_ready=0 for 200 cycles, required 1");
        end
    endtask

    task automatic rand_cell();
        pattern = PAT_W'($urandom);
        color   = (2*COL_W)'($urandom);
        fg_text = COL_W'($urandom);
        bg_text = COL_W'($urandom);
        mode    = 2'($urandom_range(0, 3));
    endtask

    task automatic test_reset();
        rst = 1'b1; pat_valid = 1'b0; flush = 1'b0;
        repeat (3) step();
        #1;
        n_cmp++;
        if (pat_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_ready_low: got %b need 0", pat_ready);
        end
        rst = 1'b0;
        step();
        n_cmp++;
        if (pix_valid !== 1'b0 || pix_color !== '0 || underrun !== 1'b0 || pat_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_state: valid=%b color=%h underrun=%b ready=%b need 0/0/0/1",
                     pix_valid, pix_color, underrun, pat_ready);
        end
    endtask

    task automatic test_graphics();
        logic [3:0] exp;
        backdrop = 4'h7;
        for (int c = 0; c < 2; c++) begin
            if (c == 0) offer(8'hA5, 8'h41, 2'd0, 4'h0, 4'h0);
            else        offer(8'h0F, 8'h40, 2'd0, 4'h0, 4'h0);
            n_cmp++;
            if (pix_valid !== 1'b0) begin
                n_bad++; $display("FAIL gfx_latency case %0d: valid=%b need 0", c, pix_valid);
            end
            for (int t = 0; t < PAT_W*HREP; t++) begin
                step();
                exp = (c == 0) ? EXP_A5[t/HREP] : EXP_0F[t/HREP];
                n_cmp++;
                if (pix_valid !== 1'b1 || pix_color !== exp || underrun !== 1'b0) begin
                    n_bad++;
                    $display("FAIL gfx_pixel case %0d clk %0d: valid=%b color=%h ur=%b need 1/%h/0",
                             c, t, pix_valid, pix_color, underrun, exp);
                end
            end
            step();
            n_cmp++;
            if (pix_valid !== 1'b0 || underrun !== 1'b1) begin
                n_bad++;
                $display("FAIL gfx_underrun case %0d: valid=%b ur=%b need 0/1", c, pix_valid, underrun);
            end
            step();
            n_cmp++;
            if (underrun !== 1'b0) begin
                n_bad++; $display("FAIL gfx_underrun_width case %0d: ur=%b need 0", c, underrun);
            end
        end
    endtask

    task automatic test_text_back_to_back();
        logic exp_ready;
        int   last;
        last = 2*TEXT_PIX*HREP;
        backdrop = 4'h7;
        offer(8'hFC, 8'h00, 2'd1, 4'hF, 4'h4);
        for (int t = 1; t <= last + 1; t++) begin
            step();
            n_cmp++;
            if (t <= last) begin
                if (pix_valid !== 1'b1 || pix_color !== EXP_TEXT[(t-1)/HREP] || underrun !== 1'b0) begin
                    n_bad++;
                    $display("FAIL text_pixel clk %0d: valid=%b color=%h ur=%b need 1/%h/0",
                             t, pix_valid, pix_color, underrun, EXP_TEXT[(t-1)/HREP]);
                end
            end else if (pix_valid !== 1'b0 || underrun !== 1'b1) begin
                n_bad++;
                $display("FAIL text_underrun: valid=%b ur=%b need 0/1", pix_valid, underrun);
            end
            if (t == 1) begin
                pattern = 8'h84; fg_text = 4'hF; bg_text = 4'h4; mode = 2'd1;
                pat_valid = 1'b1;
            end
            if (t == 2) begin
                pat_valid = 1'b0;
                mode = 2'd0;
            end
            #1;
            if (t == 1) begin
                n_cmp++;
                if (pat_ready !== 1'b1) begin
                    n_bad++; $display("FAIL text_accept2: ready=%b need 1", pat_ready);
                end
            end
            if (t >= 2 && t <= 20) begin
                exp_ready = (t >= TEXT_PIX*HREP);
                n_cmp++;
                if (pat_ready !== exp_ready) begin
                    n_bad++; $display("FAIL text_ready clk %0d: ready=%b need %b", t, pat_ready, exp_ready);
                end
            end
        end
        step();
    endtask

    task automatic test_multicolor();
        logic [3:0] exp;
        backdrop = 4'h7;
        for (int c = 0; c < 2; c++) begin
            offer((c == 0) ? 8'hFF : 8'h00, 8'h3C, 2'd2, 4'h0, 4'h0);
            for (int t = 0; t < PAT_W*HREP; t++) begin
                step();
                exp = (t < 12) ? 4'h3 : 4'hC;
                n_cmp++;
                if (pix_valid !== 1'b1 || pix_color !== exp) begin
                    n_bad++;
                    $display("FAIL multi_pixel case %0d clk %0d: valid=%b color=%h need 1/%h",
                             c, t, pix_valid, pix_color, exp);
                end
            end
            step();
            n_cmp++;
            if (underrun !== 1'b1) begin
                n_bad++; $display("FAIL multi_underrun case %0d: ur=%b need 1", c, underrun);
            end
            step();
        end
    endtask

    task automatic test_flush();
        int bad_idle;
        backdrop = 4'h7;
        offer(8'hA5, 8'h41, 2'd0, 4'h0, 4'h0);
        for (int t = 1; t <= 10; t++) begin
            step();
            n_cmp++;
            if (pix_valid !== 1'b1 || pix_color !== EXP_A5[(t-1)/HREP]) begin
                n_bad++;
                $display("FAIL flush_pre clk %0d: valid=%b color=%h need 1/%h",
                         t, pix_valid, pix_color, EXP_A5[(t-1)/HREP]);
            end
            if (t == 1) begin
                pattern = 8'hFF; color = 8'h22; pat_valid = 1'b1;
            end
            if (t == 2) pat_valid = 1'b0;
        end
        flush = 1'b1;
        pattern = 8'hFF; color = 8'h99; pat_valid = 1'b1;
        #1;
        n_cmp++;
        if (pat_ready !== 1'b0) begin
            n_bad++; $display("FAIL flush_ready: ready=%b need 0", pat_ready);
        end
        step();
        flush = 1'b0; pat_valid = 1'b0;
        n_cmp++;
        if (pix_valid !== 1'b0 || underrun !== 1'b0) begin
            n_bad++; $display("FAIL flush_out: valid=%b ur=%b need 0/0", pix_valid, underrun);
        end
        bad_idle = 0;
        for (int t = 0; t < 30; t++) begin
            step();
            if (pix_valid !== 1'b0 || underrun !== 1'b0) bad_idle++;
        end
        n_cmp++;
        if (bad_idle != 0) begin
            n_bad++; $display("FAIL flush_idle: active cycles=%0d need 0", bad_idle);
        end
        offer(8'h0F, 8'h40, 2'd0, 4'h0, 4'h0);
        n_cmp++;
        if (pix_valid !== 1'b0) begin
            n_bad++; $display("FAIL flush_restart_latency: valid=%b need 0", pix_valid);
        end
        step();
        n_cmp++;
        if (pix_valid !== 1'b1 || pix_color !== 4'h7) begin
            n_bad++; $display("FAIL flush_restart: valid=%b color=%h need 1/7", pix_valid, pix_color);
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        step();
    endtask

    task automatic test_rst_mid_cell();
        int bad_idle;
        backdrop = 4'h7;
        offer(8'hA5, 8'h41, 2'd0, 4'h0, 4'h0);
        for (int t = 1; t <= 5; t++) begin
            step();
            if (t == 1) begin
                pattern = 8'h3C; color = 8'h56; pat_valid = 1'b1;
            end
            if (t == 2) pat_valid = 1'b0;
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (pat_ready !== 1'b0) begin
            n_bad++; $display("FAIL rst_ready_low: ready=%b need 0", pat_ready);
        end
        step();
        rst = 1'b0;
        #1;
        n_cmp++;
        if (pix_valid !== 1'b0 || pix_color !== '0 || underrun !== 1'b0 || pat_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_out: valid=%b color=%h ur=%b ready=%b need 0/0/0/1",
                     pix_valid, pix_color, underrun, pat_ready);
        end
        bad_idle = 0;
        for (int t = 0; t < 10; t++) begin
            step();
            if (pix_valid !== 1'b0 || underrun !== 1'b0) bad_idle++;
        end
        n_cmp++;
        if (bad_idle != 0) begin
            n_bad++; $display("FAIL rst_idle: active cycles=%0d need 0", bad_idle);
        end
        backdrop = 4'h5;
        offer(PAT_W'($urandom), 8'hA3, 2'd3, 4'h1, 4'h2);
        for (int t = 0; t < PAT_W*HREP; t++) begin
            step();
            n_cmp++;
            if (pix_valid !== 1'b1 || pix_color !== 4'h5) begin
                n_bad++;
                $display("FAIL blank_pixel clk %0d: valid=%b color=%h need 1/5", t, pix_valid, pix_color);
            end
        end
        step();
        n_cmp++;
        if (underrun !== 1'b1 || pix_valid !== 1'b0) begin
            n_bad++; $display("FAIL blank_underrun: valid=%b ur=%b need 0/1", pix_valid, underrun);
        end
        step();
    endtask

    task automatic test_random_stream();
        logic [COL_W-1:0] expq[$];
        logic [COL_W-1:0] exp;
        int  ncells, sent, gaps, urs, extra;
        bit  started, accepted, done;
        ncells = 40; sent = 0; gaps = 0; urs = 0; extra = 0;
        started = 1'b0; done = 1'b0;
        backdrop = COL_W'($urandom_range(1, 15));
        rand_cell();
        pat_valid = 1'b1;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            #1;
            accepted = pat_valid && pat_ready;
            if (accepted) begin
                for (int k = 0; k < ((mode == 2'd1) ? TEXT_PIX : PAT_W); k++)
                    for (int r = 0; r < HREP; r++)
                        expq.push_back(ref_pix(pattern, color, mode, fg_text, bg_text, backdrop, k));
                sent++;
            end
            step();
            if (underrun === 1'b1) urs++;
            if (pix_valid === 1'b1) begin
                started = 1'b1;
                if (expq.size() == 0) begin
                    extra++;
                end else begin
                    exp = expq.pop_front();
                    n_cmp++;
                    if (pix_color !== exp) begin
                        n_bad++;
                        $display("FAIL rand_pixel cyc %0d: color=%h need %h", cyc, pix_color, exp);
                    end
                end
            end else if (started && expq.size() != 0) begin
                gaps++;
            end
            if (accepted) begin
                if (sent < ncells) rand_cell();
                else pat_valid = 1'b0;
            end
            if (sent == ncells && expq.size() == 0 && pix_valid !== 1'b1) done = 1'b1;
        end
        pat_valid = 1'b0;
        n_cmp++;
        if (!done) begin
            n_bad++; $display("FAIL rand_timeout: %0d pixels outstanding, need 0", expq.size());
        end
        n_cmp++;
        if (gaps != 0 || extra != 0) begin
            n_bad++; $display("FAIL rand_gapless: gaps=%0d extra=%0d need 0/0", gaps, extra);
        end
        n_cmp++;
        if (urs != 1) begin
            n_bad++; $display("FAIL rand_underruns: got %0d need 1", urs);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_graphics();
        test_text_back_to_back();
        test_multicolor();
        test_flush();
        test_rst_mid_cell();
        test_random_stream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
